// File: rtl/axil_rd_ctrl.sv
// axil_rd_ctrl -- AXI4-Lite read-channel controller in front of a word memory
// with a fixed one-cycle read latency.
//
// Accepts up to DEPTH outstanding reads. Each accepted AR issues one memory
// read strobe. The returned word is captured one cycle later into a
// DEPTH-entry response FIFO. Responses come back strictly in acceptance order.
//
// Optional feature (compile-time macro AXIL_RD_RANGE_CHECK_EN):
//   defined   -> word indices >= MEM_WORDS skip the memory access and return
//                RDATA=0 with RRESP=SLVERR, using the normal latency and order.
//   undefined -> no range check; the word index is truncated to the memory
//                address width and RRESP is always OKAY.
//
// Ports:
//   CLK, RSTn         clock (rising edge), asynchronous active-low reset
//   ARVALID/ARREADY   read address handshake, ARADDR = byte address
//   RVALID/RREADY     read data handshake, RDATA/RRESP = head of response FIFO
//   mem_rd_en         memory read strobe (AR handshake cycle only)
//   mem_rd_addr       memory word index
//   mem_rd_data       memory word, valid the cycle after mem_rd_en
module axil_rd_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 2,
  parameter int MEM_WORDS  = 16,
  localparam int MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  mem_rd_en,
  output logic [MEM_AW-1:0]     mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int OFF   = $clog2(DATA_WIDTH / 8);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  // occ counts reads in flight plus reads stored; cnt counts stored only.
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [OCC_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  pend_q, pend_d;
  logic                  pend_err_q, pend_err_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
  logic [1:0]            fifo_resp_q [DEPTH];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  range_err;
  logic                  ar_hs;
  logic                  r_hs;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [1:0]            cap_resp;
  logic                  unused_idx;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign word_idx   = ARADDR >> OFF;
  assign unused_idx = ^word_idx;

`ifdef AXIL_RD_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH:0] MEM_WORDS_C = (ADDR_WIDTH + 1)'(MEM_WORDS);
  assign range_err = ({1'b0, word_idx} >= MEM_WORDS_C);
`else
  assign range_err = 1'b0;
`endif

  // ARREADY comes only from registered occupancy; a retirement frees a slot
  // for the following cycle, never the same one.
  assign ARREADY     = (occ_q < DEPTH_C);
  assign RVALID      = (cnt_q != '0);
  assign ar_hs       = ARVALID && ARREADY;
  assign r_hs        = RVALID && RREADY;
  assign mem_rd_en   = ar_hs && !range_err;
  assign mem_rd_addr = word_idx[MEM_AW-1:0];

  // Storage is not reset, so the outputs are forced to zero while empty.
  assign RDATA = RVALID ? fifo_data_q[rd_ptr_q] : '0;
  assign RRESP = RVALID ? fifo_resp_q[rd_ptr_q] : 2'b00;

  always_comb begin
    occ_d      = occ_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pend_d     = ar_hs;
    pend_err_d = ar_hs && range_err;
    cap_data   = pend_err_q ? '0 : mem_rd_data;
    cap_resp   = pend_err_q ? 2'b10 : 2'b00;

    case ({ar_hs, r_hs})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    case ({pend_q, r_hs})
      2'b10:   cnt_d = cnt_q + OCC_W'(1);
      2'b01:   cnt_d = cnt_q - OCC_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (pend_q) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (r_hs)   rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      occ_q      <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pend_q     <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pend_q     <= pend_d;
      pend_err_q <= pend_err_d;
    end
  end

  // Capture the memory word the cycle after the strobe. occ bounds stored
  // plus in-flight entries, so the write slot is never the live head.
  always_ff @(posedge CLK) begin
    if (pend_q) begin
      fifo_data_q[wr_ptr_q] <= cap_data;
      fifo_resp_q[wr_ptr_q] <= cap_resp;
    end
  end

endmodule

// File: tb/tb_axil_rd_ctrl.sv
module tb_axil_rd_ctrl;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 7;
  localparam int DEPTH      = 3;
  localparam int MEM_WORDS  = 16;

  logic                  CLK = 1'b0;
  logic                  RSTn;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  RVALID;
  logic                  RREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  mem_rd_en;
  logic [3:0]            mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  axil_rd_ctrl #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH(DEPTH),
    .MEM_WORDS(MEM_WORDS)
  ) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .ARADDR(ARADDR),
    .RVALID(RVALID),
    .RREADY(RREADY),
    .RDATA(RDATA),
    .RRESP(RRESP),
    .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data)
  );

  always #5 CLK = ~CLK;

  // Memory with one-cycle read latency; garbage when not strobed so that
  // error entries that wrongly sample the bus are caught.
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  always @(posedge CLK) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : $urandom;

  // Reference model: every accepted read becomes one expected response,
  // available two cycles after acceptance, retired in acceptance order.
  typedef struct {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    int                    avail;
  } exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int beats = 0;
  int first_beat = -1;
  int last_beat = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic arv, input logic [ADDR_WIDTH-1:0] addr,
                      input logic rr, output logic acc);
    logic       exp_ard;
    logic       exp_rv;
    logic       err;
    logic [4:0] idx;
    exp_t       e;
    @(negedge CLK);
    ARVALID = arv;
    ARADDR  = addr;
    RREADY  = rr;
    #1;
    exp_ard = (q.size() < DEPTH);
    exp_rv  = (q.size() > 0) && (q[0].avail <= cyc);
    chk("arready", 64'(ARREADY), 64'(exp_ard));
    chk("rvalid", 64'(RVALID), 64'(exp_rv));
    if (exp_rv) begin
      chk("rdata", 64'(RDATA), 64'(q[0].data));
      chk("rresp", 64'(RRESP), 64'(q[0].resp));
    end
    if (RVALID && rr) begin
      beats++;
      last_beat = cyc;
      if (first_beat < 0) first_beat = cyc;
    end
    acc = arv && exp_ard;
    idx = addr / 4;
`ifdef AXIL_RD_RANGE_CHECK_EN
    err = (idx >= 5'd16);
`else
    err = 1'b0;
`endif
    chk("mem_rd_en", 64'(mem_rd_en), 64'(acc && !err));
    if (acc && !err) chk("mem_rd_addr", 64'(mem_rd_addr), 64'(idx % 16));
    if (exp_rv && rr) void'(q.pop_front());
    if (acc) begin
      e.data  = err ? '0 : mem[idx % 16];
      e.resp  = err ? 2'b10 : 2'b00;
      e.avail = cyc + 2;
      q.push_back(e);
    end
    cyc++;
  endtask

  task automatic drain(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, a);
  endtask

  initial begin
    logic a;
    int   acc_cyc;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    mem[2] = 32'hDEADBEEF;

    // Power-on reset
    RSTn = 1'b0; ARVALID = 1'b0; RREADY = 1'b0; ARADDR = '0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_arready", 64'(ARREADY), 64'(1'b1));
    chk("rst_rvalid", 64'(RVALID), 64'(1'b0));
    chk("rst_rdata", 64'(RDATA), 64'(0));
    chk("rst_rresp", 64'(RRESP), 64'(2'b00));
    chk("rst_mem_rd_en", 64'(mem_rd_en), 64'(1'b0));
    RSTn = 1'b1;

    // Single read of word 2
    step(1'b1, 7'h08, 1'b1, a);
    drain(4);

    // Backpressure: DEPTH accepted, the rest rejected until a slot frees
    for (int i = 0; i < 6; i++)
      step(1'b1, ADDR_WIDTH'(((i < DEPTH) ? i : DEPTH) * 4 + 16), 1'b0, a);
    first_beat = -1;
    acc_cyc = -1;
    for (int i = 0; i < 8 && acc_cyc < 0; i++) begin
      step(1'b1, ADDR_WIDTH'(DEPTH * 4 + 16), 1'b1, a);
      if (a) acc_cyc = cyc - 1;
    end
    chk("bp_accepted", 64'(acc_cyc >= 0), 64'(1'b1));
    chk("bp_accept_lag", 64'(acc_cyc - first_beat), 64'(1));
    drain(6);

    // Streaming: 8 back-to-back reads to words 0..7
    beats = 0; first_beat = -1; last_beat = -1;
    acc_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, ADDR_WIDTH'(i * 4), 1'b1, a);
      chk("stream_acc", 64'(a), 64'(1'b1));
    end
    drain(4);
    chk("stream_beats", 64'(beats), 64'(8));
    chk("stream_first", 64'(first_beat - acc_cyc), 64'(2));
    chk("stream_span", 64'(last_beat - first_beat), 64'(7));

    // Out-of-range word index (word 16) and neighbours
    step(1'b1, 7'h40, 1'b1, a);
    step(1'b1, 7'h3C, 1'b1, a);
    step(1'b1, 7'h7F, 1'b1, a);
    drain(5);

    // Reset with reads outstanding
    step(1'b1, 7'h04, 1'b0, a);
    step(1'b1, 7'h0C, 1'b0, a);
    step(1'b0, 7'h00, 1'b0, a);
    @(negedge CLK);
    ARVALID = 1'b0; RREADY = 1'b0; RSTn = 1'b0;
    #1;
    chk("mid_rst_rvalid", 64'(RVALID), 64'(1'b0));
    chk("mid_rst_arready", 64'(ARREADY), 64'(1'b1));
    chk("mid_rst_rdata", 64'(RDATA), 64'(0));
    q.delete();
    @(negedge CLK);
    RSTn = 1'b1;
    cyc += 2;
    drain(5);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) < 7), ADDR_WIDTH'($urandom), $urandom_range(0, 1) == 1, a);
    drain(8);
    chk("final_empty", 64'(q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
